// File: rtl/dataio_arbiter_if.sv
// rtl/dataio_arbiter_if.sv - requester and shared data-port interfaces for dataio_arbiter
// Requesters are masters of dataio_req_if; the arbiter is master of dataio_port_if.
interface dataio_req_if;
   logic        req;
   logic        busy;
   logic [1:0]  order;
   logic        rw;
   logic [13:0] tid;
   logic [1:0]  mmumod;
   logic [31:0] pdt;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        valid;
   logic [31:0] rdata;

   modport master (output req, order, rw, tid, mmumod, pdt, addr, wdata,
                   input  busy, valid, rdata);
   modport slave  (input  req, order, rw, tid, mmumod, pdt, addr, wdata,
                   output busy, valid, rdata);
endinterface

interface dataio_port_if;
   logic        req;
   logic [1:0]  order;
   logic        rw;
   logic [13:0] tid;
   logic [1:0]  mmumod;
   logic [31:0] pdt;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, order, rw, tid, mmumod, pdt, addr, wdata,
                   input  busy, rvalid, rdata);
   modport slave  (input  req, order, rw, tid, mmumod, pdt, addr, wdata,
                   output busy, rvalid, rdata);
endinterface

// File: rtl/dataio_arbiter.sv
// rtl/dataio_arbiter.sv - two-requester arbiter onto one shared data port, one transaction in flight
// Optional feature: DATAIO_ARBITER_ROUND_ROBIN_EN selects round-robin instead of fixed S0 priority.
module dataio_arbiter (
   input  logic          iCLOCK,
   input  logic          inRESET,
   dataio_req_if.slave   s0,
   dataio_req_if.slave   s1,
   dataio_port_if.master dio
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RD_WAIT = 2'd2} state_t;

   state_t      state_q,  state_d;
   logic        owner_q,  owner_d;
   logic [1:0]  order_q,  order_d;
   logic        rw_q,     rw_d;
   logic [13:0] tid_q,    tid_d;
   logic [1:0]  mmumod_q, mmumod_d;
   logic [31:0] pdt_q,    pdt_d;
   logic [31:0] addr_q,   addr_d;
   logic [31:0] wdata_q,  wdata_d;
`ifdef DATAIO_ARBITER_ROUND_ROBIN_EN
   logic        last_q,   last_d;
`endif

   logic grant0, grant1, accept, resp_valid;

   // Grants are only possible in IDLE, which also makes busy purely combinational there.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == IDLE) begin
`ifdef DATAIO_ARBITER_ROUND_ROBIN_EN
         if (s0.req && s1.req) begin
            grant0 = last_q;
            grant1 = ~last_q;
         end else begin
            grant0 = s0.req;
            grant1 = s1.req;
         end
`else
         grant0 = s0.req;
         grant1 = s1.req & ~s0.req;
`endif
      end
   end

   assign accept  = grant0 | grant1;
   assign s0.busy = (state_q != IDLE) | (s0.req & ~grant0);
   assign s1.busy = (state_q != IDLE) | (s1.req & ~grant1);

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      order_d  = order_q;
      rw_d     = rw_q;
      tid_d    = tid_q;
      mmumod_d = mmumod_q;
      pdt_d    = pdt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
`ifdef DATAIO_ARBITER_ROUND_ROBIN_EN
      last_d   = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               owner_d  = grant1;
               order_d  = grant1 ? s1.order  : s0.order;
               rw_d     = grant1 ? s1.rw     : s0.rw;
               tid_d    = grant1 ? s1.tid    : s0.tid;
               mmumod_d = grant1 ? s1.mmumod : s0.mmumod;
               pdt_d    = grant1 ? s1.pdt    : s0.pdt;
               addr_d   = grant1 ? s1.addr   : s0.addr;
               wdata_d  = grant1 ? s1.wdata  : s0.wdata;
`ifdef DATAIO_ARBITER_ROUND_ROBIN_EN
               last_d   = grant1;
`endif
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            if (!dio.busy) state_d = rw_q ? IDLE : RD_WAIT;
         end
         RD_WAIT: begin
            if (dio.rvalid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iCLOCK) begin
      if (!inRESET) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         order_q  <= '0;
         rw_q     <= 1'b0;
         tid_q    <= '0;
         mmumod_q <= '0;
         pdt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
`ifdef DATAIO_ARBITER_ROUND_ROBIN_EN
         last_q   <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         order_q  <= order_d;
         rw_q     <= rw_d;
         tid_q    <= tid_d;
         mmumod_q <= mmumod_d;
         pdt_q    <= pdt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
`ifdef DATAIO_ARBITER_ROUND_ROBIN_EN
         last_q   <= last_d;
`endif
      end
   end

   assign dio.req    = (state_q == ISSUE);
   assign dio.rw     = rw_q & dio.req;
   assign dio.order  = order_q;
   assign dio.tid    = tid_q;
   assign dio.mmumod = mmumod_q;
   assign dio.pdt    = pdt_q;
   assign dio.addr   = addr_q;
   assign dio.wdata  = wdata_q;

   // Responses outside RD_WAIT are dropped, so a stale return after reset cannot leak out.
   assign resp_valid = (state_q == RD_WAIT) & dio.rvalid;
   assign s0.valid   = resp_valid & ~owner_q;
   assign s1.valid   = resp_valid &  owner_q;
   assign s0.rdata   = s0.valid ? dio.rdata : 32'h0;
   assign s1.rdata   = s1.valid ? dio.rdata : 32'h0;

endmodule

// File: tb/tb_dataio_arbiter.sv
// tb/tb_dataio_arbiter.sv - self-checking bench for dataio_arbiter against a transaction-level model
module tb_dataio_arbiter;

   typedef struct {
      logic [1:0]  order;
      logic        rw;
      logic [13:0] tid;
      logic [1:0]  mmumod;
      logic [31:0] pdt;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_last = 1;

   always #5 clk = ~clk;

   dataio_req_if  s0 ();
   dataio_req_if  s1 ();
   dataio_port_if dio ();

   dataio_arbiter dut (
      .iCLOCK (clk),
      .inRESET(rstn),
      .s0     (s0),
      .s1     (s1),
      .dio    (dio)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   function automatic txn_t rand_txn();
      txn_t t;
      t.order  = 2'($urandom_range(0, 2));
      t.rw     = 1'($urandom_range(0, 1));
      t.tid    = 14'($urandom);
      t.mmumod = 2'($urandom);
      t.pdt    = $urandom;
      t.addr   = $urandom;
      t.wdata  = $urandom;
      return t;
   endfunction

   task automatic drive(input int x, input logic req, input txn_t t);
      if (x == 0) begin
         s0.req = req; s0.order = t.order; s0.rw = t.rw; s0.tid = t.tid;
         s0.mmumod = t.mmumod; s0.pdt = t.pdt; s0.addr = t.addr; s0.wdata = t.wdata;
      end else begin
         s1.req = req; s1.order = t.order; s1.rw = t.rw; s1.tid = t.tid;
         s1.mmumod = t.mmumod; s1.pdt = t.pdt; s1.addr = t.addr; s1.wdata = t.wdata;
      end
   endtask

   // Arbitration rule: lone request wins; on a tie S0 wins, or the one not granted last.
   function automatic int pick(input bit r0, input bit r1);
      if (r0 && r1) begin
`ifdef DATAIO_ARBITER_ROUND_ROBIN_EN
         return (exp_last == 1) ? 0 : 1;
`else
         return 0;
`endif
      end
      return r0 ? 0 : 1;
   endfunction

   task automatic chk_port(input string tag, input txn_t t);
      chk({tag, ".req"},    dio.req,    1'b1);
      chk({tag, ".rw"},     dio.rw,     t.rw);
      chk({tag, ".order"},  dio.order,  t.order);
      chk({tag, ".tid"},    dio.tid,    t.tid);
      chk({tag, ".mmumod"}, dio.mmumod, t.mmumod);
      chk({tag, ".pdt"},    dio.pdt,    t.pdt);
      chk({tag, ".addr"},   dio.addr,   t.addr);
      chk({tag, ".wdata"},  dio.wdata,  t.wdata);
   endtask

   task automatic chk_quiet(input string tag, input logic b0, input logic b1);
      chk({tag, ".dreq"},   dio.req,  1'b0);
      chk({tag, ".drw"},    dio.rw,   1'b0);
      chk({tag, ".valid0"}, s0.valid, 1'b0);
      chk({tag, ".valid1"}, s1.valid, 1'b0);
      chk({tag, ".rdata0"}, s0.rdata, 32'h0);
      chk({tag, ".rdata1"}, s1.rdata, 32'h0);
      chk({tag, ".busy0"},  s0.busy,  b0);
      chk({tag, ".busy1"},  s1.busy,  b1);
   endtask

   // One full transaction starting in IDLE at posedge+1; nb/d < 0 mean random busy/latency.
   task automatic run_txn(input bit r0, input bit r1, input bit fixed, input txn_t f,
                          input int nb_in, input int d_in, input logic [31:0] rd_in);
      txn_t t0, t1, win;
      int   w, nb, d;
      logic [31:0] rd;
      t0 = rand_txn();
      t1 = rand_txn();
      w  = pick(r0, r1);
      if (fixed) begin
         if (w == 0) t0 = f; else t1 = f;
      end
      win = (w == 0) ? t0 : t1;
      nb  = (nb_in < 0) ? $urandom_range(0, 3) : nb_in;
      d   = (d_in  < 0) ? $urandom_range(0, 2) : d_in;
      rd  = fixed ? rd_in : $urandom;
      drive(0, r0, t0);
      drive(1, r1, t1);
      dio.busy = 1'b0; dio.rvalid = 1'b0;
      sample();
      chk("arb.busy0", s0.busy, r0 && (w != 0));
      chk("arb.busy1", s1.busy, r1 && (w != 1));
      chk("arb.dreq",  dio.req, 1'b0);
      tick();
      exp_last = w;
      drive(0, 1'b0, rand_txn());
      drive(1, 1'b0, rand_txn());
      for (int i = 0; i <= nb; i++) begin
         dio.busy   = (i < nb);
         dio.rvalid = 1'($urandom_range(0, 1));
         dio.rdata  = $urandom;
         sample();
         chk_port("issue", win);
         chk("issue.busy0",  s0.busy,  1'b1);
         chk("issue.busy1",  s1.busy,  1'b1);
         chk("issue.valid0", s0.valid, 1'b0);
         chk("issue.valid1", s1.valid, 1'b0);
         tick();
      end
      dio.busy = 1'b0; dio.rvalid = 1'b0;
      if (win.rw) begin
         sample();
         chk_quiet("wr_done", 1'b0, 1'b0);
         tick();
      end else begin
         for (int i = 0; i < d; i++) begin
            sample();
            chk_quiet("rd_wait", 1'b1, 1'b1);
            tick();
         end
         dio.rvalid = 1'b1;
         dio.rdata  = rd;
         sample();
         chk("resp.valid0", s0.valid, w == 0);
         chk("resp.valid1", s1.valid, w == 1);
         chk("resp.rdata0", s0.rdata, (w == 0) ? rd : 32'h0);
         chk("resp.rdata1", s1.rdata, (w == 1) ? rd : 32'h0);
         chk("resp.dreq",   dio.req,  1'b0);
         tick();
         dio.rvalid = 1'b0;
         dio.rdata  = $urandom;
         sample();
         chk_quiet("rd_done", 1'b0, 1'b0);
         tick();
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      exp_last = 1;
   endtask

   txn_t        zt, ft;
   logic [31:0] sv_addr, sv_wdata;
   int          pat;

   initial begin
      zt = '{2'd0, 1'b0, 14'd0, 2'd0, 32'h0, 32'h0, 32'h0};
      drive(0, 1'b0, zt);
      drive(1, 1'b0, zt);
      dio.busy = 1'b0; dio.rvalid = 1'b0; dio.rdata = 32'h0;
      #1;
      do_reset();

      sample();
      chk_quiet("reset", 1'b0, 1'b0);
      chk("reset.addr",  dio.addr,  32'h0);
      chk("reset.wdata", dio.wdata, 32'h0);
      chk("reset.pdt",   dio.pdt,   32'h0);
      chk("reset.tid",   dio.tid,   14'h0);
      s0.req = 1'b1; s1.req = 1'b1;
      #1;
      chk("reset_tie.busy0", s0.busy, 1'b0);
      chk("reset_tie.busy1", s1.busy, 1'b1);
      s0.req = 1'b0;
      #1;
      chk("lone1.busy1", s1.busy, 1'b0);
      s1.req = 1'b0;
      tick();

      // Spurious response in IDLE.
      dio.rvalid = 1'b1; dio.rdata = 32'hA5A5A5A5;
      sample();
      chk_quiet("spurious", 1'b0, 1'b0);
      tick();
      dio.rvalid = 1'b0;
      sample();
      chk_quiet("spurious_after", 1'b0, 1'b0);
      tick();

      // S0 word read at 0x100, answered two cycles after issue.
      ft = '{2'b10, 1'b0, 14'h0001, 2'b00, 32'h0, 32'h100, 32'h0};
      run_txn(1'b1, 1'b0, 1'b1, ft, 0, 1, 32'hDEADBEEF);
      // S1 write 0x12345678 at 0x200 with the port busy for three cycles.
      ft = '{2'b10, 1'b1, 14'h0002, 2'b01, 32'h1000, 32'h200, 32'h12345678};
      run_txn(1'b0, 1'b1, 1'b1, ft, 3, 0, 32'h0);

      // Back-to-back ties: alternate with round-robin, S0 every time otherwise.
      do_reset();
      for (int k = 0; k < 4; k++) run_txn(1'b1, 1'b1, 1'b0, zt, -1, -1, 32'h0);

      // S1 held through an S0 read, then accepted in the cycle after the response.
      do_reset();
      ft = rand_txn();
      ft.rw = 1'b1;
      sv_addr = ft.addr; sv_wdata = ft.wdata;
      drive(1, 1'b1, ft);
      zt.rw = 1'b0; zt.addr = 32'h300;
      drive(0, 1'b1, zt);
      sample();
      chk("hold.acc.busy0", s0.busy, 1'b0);
      chk("hold.acc.busy1", s1.busy, 1'b1);
      tick();
      s0.req = 1'b0;
      sample();
      chk("hold.issue.addr",  dio.addr, 32'h300);
      chk("hold.issue.busy1", s1.busy,  1'b1);
      tick();
      sample();
      chk("hold.wait.busy1", s1.busy, 1'b1);
      tick();
      dio.rvalid = 1'b1; dio.rdata = 32'h0BADF00D;
      sample();
      chk("hold.resp.valid0", s0.valid, 1'b1);
      chk("hold.resp.rdata0", s0.rdata, 32'h0BADF00D);
      chk("hold.resp.busy1",  s1.busy,  1'b1);
      tick();
      dio.rvalid = 1'b0;
      sample();
      chk("hold.idle.busy1", s1.busy, 1'b0);
      tick();
      s1.req = 1'b0;
      sample();
      chk("hold.s1.dreq",  dio.req,   1'b1);
      chk("hold.s1.rw",    dio.rw,    1'b1);
      chk("hold.s1.addr",  dio.addr,  sv_addr);
      chk("hold.s1.wdata", dio.wdata, sv_wdata);
      tick();
      sample();
      chk_quiet("hold.done", 1'b0, 1'b0);
      tick();
      exp_last = 1;

      // Reset while a read waits in RD_WAIT; the late response must vanish.
      zt.rw = 1'b0; zt.addr = 32'h400;
      drive(0, 1'b1, zt);
      tick();
      s0.req = 1'b0;
      tick();
      sample();
      chk("rst_rd.wait.busy0", s0.busy, 1'b1);
      chk("rst_rd.wait.dreq",  dio.req, 1'b0);
      tick();
      do_reset();
      dio.rvalid = 1'b1; dio.rdata = 32'hCAFEF00D;
      sample();
      chk_quiet("rst_rd.late", 1'b0, 1'b0);
      tick();
      dio.rvalid = 1'b0;
      sample();
      chk_quiet("rst_rd.idle", 1'b0, 1'b0);
      chk("rst_rd.addr", dio.addr, 32'h0);
      tick();

      // Random mix of lone and tied requests.
      for (int k = 0; k < 30; k++) begin
         pat = $urandom_range(1, 3);
         run_txn(pat[0], pat[1], 1'b0, zt, -1, -1, 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dataio_arbiter.md
DATAIO_ARBITER -- requirements
Module: dataio_arbiter

Interface
REQ-001 Parameters: none; widths fixed as below.
REQ-002 iCLOCK  in  1  single clock; all state updates on rising edge.
REQ-003 inRESET  in  1  reset, synchronous and active-low.
REQ-004 iSx_REQ  in  1  requester x (x=0,1) access request, held until accepted.
REQ-005 oSx_BUSY  out  1  requester x not accepted this cycle.
REQ-006 iSx_ORDER  in  2  00 byte, 01 halfword, 10 word.
REQ-007 iSx_RW  in  1  0 read, 1 write.
REQ-008 iSx_TID / iSx_MMUMOD / iSx_PDT  in  14/2/32  task id, MMU mode, page-directory base.
REQ-009 iSx_ADDR / iSx_DATA  in  32/32  address, write data.
REQ-010 oSx_VALID / oSx_DATA  out  1/32  read response strobe and data for requester x.
REQ-011 oDATAIO_REQ / ORDER / RW / TID / MMUMOD / PDT / ADDR / DATA  out  1/2/1/14/2/32/32/32  shared data port.
REQ-012 iDATAIO_BUSY  in  1  shared port cannot accept.
REQ-013 iDATAIO_REQ / iDATAIO_DATA  in  1/32  shared port read response.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE and RD_WAIT.
REQ-015 Acceptance SHALL be the cycle in which iSx_REQ=1 and oSx_BUSY=0.
REQ-016 In ISSUE and RD_WAIT, both oSx_BUSY SHALL be 1.
REQ-017 In IDLE, oSx_BUSY SHALL be 1 only for a requester that loses arbitration; this is combinational from the requests and the priority state.
REQ-018 On acceptance, the winner's ORDER, RW, TID, MMUMOD, PDT, ADDR and DATA SHALL be registered, the owner bit SHALL be recorded, and the FSM SHALL go to ISSUE; oDATAIO_REQ SHALL assert in the next cycle (latency 1).
REQ-019 In ISSUE, oDATAIO_REQ SHALL be 1 and the registered fields SHALL be held stable while iDATAIO_BUSY=1.
REQ-020 In ISSUE with iDATAIO_BUSY=0, a write SHALL go to IDLE and a read SHALL go to RD_WAIT; oDATAIO_REQ SHALL be 0 from the next cycle.
REQ-021 In RD_WAIT, oDATAIO_REQ SHALL be 0.
REQ-022 In RD_WAIT with iDATAIO_REQ=1, oSx_VALID of the owner SHALL be 1 in the same cycle, oSx_DATA SHALL equal iDATAIO_DATA, and the FSM SHALL go to IDLE.
REQ-023 oSx_VALID SHALL be 0 for the non-owner and in every state other than RD_WAIT.
REQ-024 iDATAIO_REQ received in IDLE or ISSUE SHALL be ignored.
REQ-025 oSx_DATA SHALL be iDATAIO_DATA when oSx_VALID=1, else 0.
REQ-026 At most one transaction SHALL be outstanding; a new acceptance is possible no earlier than the cycle after the return to IDLE.
REQ-027 oDATAIO_RW SHALL be the registered RW while oDATAIO_REQ=1, else 0.

Reset
REQ-028 With inRESET=0 at a clock edge, the block SHALL go to IDLE, clear all registered fields to 0, clear the owner bit to 0, and set the last-grant pointer to 1.
REQ-029 After reset, all outputs SHALL be 0 except oSx_BUSY, which follows REQ-017.
REQ-030 Reset during ISSUE or RD_WAIT SHALL abandon the transaction; a later iDATAIO_REQ SHALL be ignored per REQ-024.

Configuration
REQ-031 Macro DATAIO_ARBITER_ROUND_ROBIN_EN: when defined, simultaneous requests in IDLE SHALL be granted to the requester other than the last-grant pointer, and the pointer SHALL update on every acceptance.
REQ-032 When DATAIO_ARBITER_ROUND_ROBIN_EN is undefined, S0 SHALL always win simultaneous requests and the pointer SHALL be absent.
REQ-033 A lone request SHALL be granted in IDLE in both configurations.

Verification
REQ-034 S0 read, word at 0x100, iDATAIO_BUSY=0, response 0xDEADBEEF two cycles after issue -> oDATAIO_REQ asserts one cycle after acceptance; then oS0_VALID=1 with data 0xDEADBEEF; oS1_VALID=0.
REQ-035 S1 write 0x12345678 to 0x200 with iDATAIO_BUSY=1 for 3 cycles -> oDATAIO_REQ, ADDR and DATA are held for 4 cycles, RW=1, then IDLE; no VALID is asserted.
REQ-036 S0 and S1 request together repeatedly, with the macro defined -> grants alternate S0, S1, S0, S1; without the macro -> S0 is granted every time and S1 stays busy.
REQ-037 S1 requests while an S0 read is in RD_WAIT -> oS1_BUSY=1 until the cycle after the S0 response; S1 is accepted then.
REQ-038 inRESET=0 asserted in RD_WAIT, then iDATAIO_REQ=1 after release -> no oSx_VALID; the FSM stays in IDLE.
REQ-039 Spurious iDATAIO_REQ=1 in IDLE -> both oSx_VALID=0 and no state change.
